// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the DMA burst engine.
// Pure definitions: no latency, no flow control.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } dma_st_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

  // Word-aligned offset in, number of 32-bit words left before the next 4KB page (1..1024).
  function automatic logic [10:0] words_to_4k(input logic [11:0] addr);
    return 11'((13'(BOUNDARY_4K) - {1'b0, addr}) >> 2);
  endfunction

endpackage

// File: rtl/dma_buf_fifo.sv
// Burst staging buffer: synchronous FIFO with registered storage, show-ahead read.
// Zero-latency dout of head entry; push ignored when full, pop ignored when empty.
module dma_buf_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign dout_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din_i;
        r_wr_ptr        <= nxt_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= nxt_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// AXI4 master DMA engine: copies data_qty_i words src->dst as read-then-write INCR bursts.
// Start to arvalid 1 cycle, last bvalid to dma_fin_o 1 cycle; one channel active at a time, waits on each handshake.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              ID_W      = 4,
  parameter int              BURST_MAX = 16,
  parameter logic [ID_W-1:0] MST_ID    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_addr_i,
  input  logic [ADDR_W-1:0]   dst_addr_i,
  input  logic [DATA_W-1:0]   data_qty_i,
  output logic                busy_o,
  output logic                dma_fin_o,
  output logic                err_o,
  output logic [ID_W-1:0]     m_arid_o,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic [7:0]          m_arlen_o,
  output logic [2:0]          m_arsize_o,
  output logic [1:0]          m_arburst_o,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  input  logic [ID_W-1:0]     m_rid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  input  logic                m_rlast_i,
  input  logic                m_rvalid_i,
  output logic                m_rready_o,
  output logic [ID_W-1:0]     m_awid_o,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic [7:0]          m_awlen_o,
  output logic [2:0]          m_awsize_o,
  output logic [1:0]          m_awburst_o,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic                m_wlast_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic [ID_W-1:0]     m_bid_i,
  input  logic [1:0]          m_bresp_i,
  input  logic                m_bvalid_i,
  output logic                m_bready_o
);

  localparam int BLEN_W = $clog2(BURST_MAX + 1);

  dma_st_e             r_state;
  dma_st_e             w_nxt_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_rem;
  logic [BLEN_W-1:0]   r_blen;
  logic [BLEN_W-1:0]   r_beat;
  logic                r_err;

  logic [BLEN_W-1:0]   w_blen;
  logic [10:0]         w_cap;
  logic [ADDR_W-1:0]   w_blen_src;
  logic [ADDR_W-1:0]   w_blen_dst;
  logic [DATA_W-1:0]   w_blen_rem;
  logic [ADDR_W-1:0]   w_src_al;
  logic [ADDR_W-1:0]   w_dst_al;
  logic [ADDR_W-1:0]   w_step;
  logic [ADDR_W-1:0]   w_src_nxt;
  logic [ADDR_W-1:0]   w_dst_nxt;
  logic [DATA_W-1:0]   w_rem_nxt;
  logic                w_err_nxt;
  logic                w_r_hs;
  logic                w_r_bad;
  logic                w_wlast;
  logic [DATA_W-1:0]   w_fifo_dout;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_unused;

  assign w_unused  = ^{m_rid_i, m_bid_i, src_addr_i[1:0], dst_addr_i[1:0], w_fifo_empty, w_fifo_full};
  assign w_src_al  = {src_addr_i[ADDR_W-1:2], 2'b00};
  assign w_dst_al  = {dst_addr_i[ADDR_W-1:2], 2'b00};
  assign w_step    = ADDR_W'({r_blen, 2'b00});
  assign w_src_nxt = r_src + w_step;
  assign w_dst_nxt = r_dst + w_step;
  assign w_rem_nxt = r_rem - DATA_W'(r_blen);
  assign w_err_nxt = r_err | (m_bresp_i != AXI_RESP_OKAY);
  assign w_r_hs    = (r_state == ST_R) && m_rvalid_i;
  assign w_wlast   = (r_beat == r_blen - BLEN_W'(1));
  // An overlong burst (no rlast by beat blen) is flagged just like a short one.
  assign w_r_bad   = m_rlast_i ? (r_beat != r_blen - BLEN_W'(1)) : (r_beat >= r_blen - BLEN_W'(1));

  // Burst length for the burst about to start: taken from the inputs in IDLE, from post-B values in B.
  always_comb begin
    w_blen_src = r_src;
    w_blen_dst = r_dst;
    w_blen_rem = r_rem;
    if (r_state == ST_IDLE) begin
      w_blen_src = w_src_al;
      w_blen_dst = w_dst_al;
      w_blen_rem = data_qty_i;
    end else if (r_state == ST_B) begin
      w_blen_src = w_src_nxt;
      w_blen_dst = w_dst_nxt;
      w_blen_rem = w_rem_nxt;
    end
    w_cap = 11'(BURST_MAX);
    if (words_to_4k(w_blen_src[11:0]) < w_cap) w_cap = words_to_4k(w_blen_src[11:0]);
    if (words_to_4k(w_blen_dst[11:0]) < w_cap) w_cap = words_to_4k(w_blen_dst[11:0]);
    if (w_blen_rem < DATA_W'(w_cap)) w_blen = BLEN_W'(w_blen_rem);
    else                             w_blen = BLEN_W'(w_cap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    dma_fin_o   = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_nxt_state = (data_qty_i == '0) ? ST_DONE : ST_AR;
      end
      ST_AR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) w_nxt_state = ST_R;
      end
      ST_R: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i && m_rlast_i) w_nxt_state = ST_AW;
      end
      ST_AW: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) w_nxt_state = ST_W;
      end
      ST_W: begin
        m_wvalid_o = 1'b1;
        if (m_wready_i && w_wlast) w_nxt_state = ST_B;
      end
      ST_B: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) w_nxt_state = ((w_rem_nxt == '0) || w_err_nxt) ? ST_DONE : ST_AR;
      end
      ST_DONE: begin
        dma_fin_o   = 1'b1;
        w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_blen <= '0;
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start_i) begin
        r_src  <= w_src_al;
        r_dst  <= w_dst_al;
        r_rem  <= data_qty_i;
        r_blen <= w_blen;
        r_beat <= '0;
        r_err  <= 1'b0;
      end
      if (w_r_hs) begin
        if (m_rlast_i)             r_beat <= '0;
        else if (r_beat != r_blen) r_beat <= r_beat + BLEN_W'(1);
        if ((m_rresp_i != AXI_RESP_OKAY) || w_r_bad) r_err <= 1'b1;
      end
      if (r_state == ST_W && m_wready_i) r_beat <= w_wlast ? '0 : r_beat + BLEN_W'(1);
      if (r_state == ST_B && m_bvalid_i) begin
        r_rem <= w_rem_nxt;
        r_src <= w_src_nxt;
        r_dst <= w_dst_nxt;
        r_err <= w_err_nxt;
        if (w_nxt_state == ST_AR) r_blen <= w_blen;
      end
    end
  end

  dma_buf_fifo #(
    .DEPTH  (BURST_MAX),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_r_hs && (r_beat < r_blen)),
    .pop_i   (r_state == ST_W && m_wready_i),
    .din_i   (m_rdata_i),
    .dout_o  (w_fifo_dout),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  assign err_o       = r_err;
  assign m_arid_o    = MST_ID;
  assign m_araddr_o  = r_src;
  assign m_arlen_o   = 8'(r_blen - BLEN_W'(1));
  assign m_arsize_o  = AXI_SIZE_4B;
  assign m_arburst_o = AXI_BURST_INCR;
  assign m_awid_o    = MST_ID;
  assign m_awaddr_o  = r_dst;
  assign m_awlen_o   = 8'(r_blen - BLEN_W'(1));
  assign m_awsize_o  = AXI_SIZE_4B;
  assign m_awburst_o = AXI_BURST_INCR;
  assign m_wdata_o   = w_fifo_dout;
  assign m_wstrb_o   = '1;
  assign m_wlast_o   = w_wlast;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed bench for dma_burst_ctrl with a small AXI slave model driven on the falling edge.
module tb_dma_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [31:0] data_qty_i = '0;
  logic        busy_o, dma_fin_o, err_o;
  logic [3:0]  m_arid_o, m_awid_o;
  logic [31:0] m_araddr_o, m_awaddr_o, m_wdata_o;
  logic [7:0]  m_arlen_o, m_awlen_o;
  logic [2:0]  m_arsize_o, m_awsize_o;
  logic [1:0]  m_arburst_o, m_awburst_o;
  logic [3:0]  m_wstrb_o;
  logic        m_arvalid_o, m_rready_o, m_awvalid_o, m_wlast_o, m_wvalid_o, m_bready_o;
  logic        m_arready_i = 1'b0, m_awready_i = 1'b0, m_wready_i = 1'b0;
  logic        m_rvalid_i = 1'b0, m_rlast_i = 1'b0, m_bvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;
  logic [1:0]  m_rresp_i = '0, m_bresp_i = '0;
  logic [3:0]  m_rid_i = '0, m_bid_i = '0;

  always #5 clk = ~clk;

  dma_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .data_qty_i(data_qty_i), .busy_o(busy_o),
    .dma_fin_o(dma_fin_o), .err_o(err_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
    .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i),
    .m_rready_o(m_rready_o), .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o),
    .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i), .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] ar_q[$];
  logic [39:0] aw_q[$];
  logic [31:0] wmem[logic [31:0]];
  int  w_cnt, w_bad, fin_cnt, fin_cyc, b_cyc, first_ar_cyc, busy_cnt;
  bit  bp_en = 1'b0;
  int  err_ar_idx = 0, err_beat = 0;

  logic [31:0] rd_addr, wr_addr, c_wd;
  logic [39:0] c_ar, c_aw;
  logic        c_wl;
  int  rd_left, rd_beat, wr_len, wr_beat;
  bit  rd_act, wr_act, b_due, p_ar, p_r, p_aw, p_w, p_b;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic bit rnd();
    return bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // Slave: apply handshakes completed at the last rising edge, then drive the next cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_act = 0; wr_act = 0; b_due = 0;
        p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
        m_arready_i = 0; m_rvalid_i = 0; m_rlast_i = 0; m_rresp_i = 0; m_rdata_i = 0;
        m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
      end else begin
        if (p_ar) begin
          ar_q.push_back(c_ar);
          rd_addr = c_ar[39:8]; rd_left = int'(c_ar[7:0]) + 1; rd_beat = 0; rd_act = 1;
        end
        if (p_r) begin
          rd_addr += 4; rd_left--; rd_beat++;
          if (rd_left == 0) rd_act = 0;
        end
        if (p_aw) begin
          aw_q.push_back(c_aw);
          wr_addr = c_aw[39:8]; wr_len = int'(c_aw[7:0]); wr_beat = 0; wr_act = 1;
        end
        if (p_w) begin
          wmem[wr_addr] = c_wd; w_cnt++;
          if (c_wl != (wr_beat == wr_len)) w_bad++;
          wr_addr += 4; wr_beat++;
          if (c_wl) begin wr_act = 0; b_due = 1; end
        end
        if (p_b) b_due = 0;
        if (dma_fin_o) begin fin_cnt++; fin_cyc = cyc; end
        if (busy_o) busy_cnt++;
        if (m_arvalid_o && first_ar_cyc < 0) first_ar_cyc = cyc;

        m_arready_i = rnd(); m_awready_i = rnd(); m_wready_i = rnd();
        if (!(m_rvalid_i && !p_r)) m_rvalid_i = rd_act && rnd();
        m_rdata_i = src_word(rd_addr);
        m_rlast_i = (rd_left == 1);
        m_rresp_i = (err_ar_idx != 0 && ar_q.size() == err_ar_idx && rd_beat + 1 == err_beat) ? 2'b10 : 2'b00;
        if (!(m_bvalid_i && !p_b)) m_bvalid_i = b_due && rnd();

        p_ar = m_arvalid_o && m_arready_i; c_ar = {m_araddr_o, m_arlen_o};
        p_r  = m_rvalid_i && m_rready_o;
        p_aw = m_awvalid_o && m_awready_i; c_aw = {m_awaddr_o, m_awlen_o};
        p_w  = m_wvalid_o && m_wready_i; c_wd = m_wdata_o; c_wl = m_wlast_o;
        p_b  = m_bvalid_i && m_bready_o;
        if (p_b) b_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] q);
    @(negedge clk);
    ar_q.delete(); aw_q.delete(); wmem.delete();
    w_cnt = 0; w_bad = 0; fin_cnt = 0; fin_cyc = -1; b_cyc = -1; first_ar_cyc = -1; busy_cnt = 0;
    src_addr_i = s; dst_addr_i = d; data_qty_i = q; start_i = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0; src_addr_i = 32'hFFFF_FFF0; dst_addr_i = 32'hFFFF_FFF0; data_qty_i = 32'd99;
  endtask

  task automatic wait_done(input int max_cyc);
    int i = 0;
    while (!dma_fin_o && i < max_cyc) begin @(negedge clk); i++; end
    chk("fin_seen", 64'(dma_fin_o), 64'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_w(input int max_cyc);
    int i = 0;
    while (!m_wvalid_o && i < max_cyc) begin @(negedge clk); i++; end
    chk("w_phase_seen", 64'(m_wvalid_o), 64'(1));
  endtask

  task automatic chk_data(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (!wmem.exists(d + 32'(4 * i)) || wmem[d + 32'(4 * i)] !== src_word(s + 32'(4 * i))) bad++;
    end
    chk({tag, "_words"}, 64'(bad), 64'(0));
    chk({tag, "_nwr"}, 64'(wmem.num()), 64'(n));
  endtask

  task automatic chk_bursts(input string tag, input logic [39:0] ea[], input logic [39:0] ew[]);
    chk({tag, "_nar"}, 64'(ar_q.size()), 64'(ea.size()));
    chk({tag, "_naw"}, 64'(aw_q.size()), 64'(ew.size()));
    for (int i = 0; i < ea.size() && i < ar_q.size(); i++) chk($sformatf("%s_ar%0d", tag, i), 64'(ar_q[i]), 64'(ea[i]));
    for (int i = 0; i < ew.size() && i < aw_q.size(); i++) chk($sformatf("%s_aw%0d", tag, i), 64'(aw_q[i]), 64'(ew[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valids", 64'({m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o, m_bready_o}), 64'(0));
    chk("reset_status", 64'({busy_o, dma_fin_o, err_o}), 64'(0));
    chk("reset_araddr", 64'(m_araddr_o), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single 5-word burst
    start_xfer(32'h1000, 32'h2000, 32'd5);
    wait_done(500);
    chk_bursts("t1", '{{32'h1000, 8'd4}}, '{{32'h2000, 8'd4}});
    chk("t1_wbeats", 64'(w_cnt), 64'(5));
    chk("t1_wlast", 64'(w_bad), 64'(0));
    chk("t1_ar_lat", 64'(first_ar_cyc), 64'(start_cyc + 1));
    chk("t1_fin_lat", 64'(fin_cyc), 64'(b_cyc + 1));
    chk("t1_fin_cnt", 64'(fin_cnt), 64'(1));
    chk("t1_err", 64'(err_o), 64'(0));
    chk("t1_arsize", 64'({m_arsize_o, m_arburst_o, m_awsize_o, m_awburst_o}), 64'({3'b010, 2'b01, 3'b010, 2'b01}));
    chk("t1_wstrb", 64'(m_wstrb_o), 64'(4'hF));
    chk_data("t1", 32'h1000, 32'h2000, 5);

    // 2: 40 words split 16/16/8
    start_xfer(32'h0, 32'h8000, 32'd40);
    wait_done(1000);
    chk_bursts("t2", '{{32'h0, 8'd15}, {32'h40, 8'd15}, {32'h80, 8'd7}},
                     '{{32'h8000, 8'd15}, {32'h8040, 8'd15}, {32'h8080, 8'd7}});
    chk("t2_wbeats", 64'(w_cnt), 64'(40));
    chk("t2_wlast", 64'(w_bad), 64'(0));
    chk("t2_fin_cnt", 64'(fin_cnt), 64'(1));
    chk_data("t2", 32'h0, 32'h8000, 40);

    // 3: source crosses a 4KB page after 2 words
    start_xfer(32'h0FF8, 32'h3000, 32'd8);
    wait_done(500);
    chk_bursts("t3", '{{32'h0FF8, 8'd1}, {32'h1000, 8'd5}}, '{{32'h3000, 8'd1}, {32'h3008, 8'd5}});
    chk("t3_wlast", 64'(w_bad), 64'(0));
    chk_data("t3", 32'h0FF8, 32'h3000, 8);

    // 4: zero-length transfer
    start_xfer(32'h5000, 32'h6000, 32'd0);
    wait_done(20);
    chk("t4_nar", 64'(ar_q.size()), 64'(0));
    chk("t4_naw", 64'(aw_q.size()), 64'(0));
    chk("t4_fin_lat", 64'(fin_cyc), 64'(start_cyc + 1));
    chk("t4_busy_cyc", 64'(busy_cnt), 64'(1));
    chk("t4_fin_cnt", 64'(fin_cnt), 64'(1));

    // 5: SLVERR on beat 3 of the first burst aborts after its write completes
    err_ar_idx = 1; err_beat = 3;
    start_xfer(32'h0, 32'h9000, 32'd32);
    wait_done(1000);
    err_ar_idx = 0;
    chk_bursts("t5", '{{32'h0, 8'd15}}, '{{32'h9000, 8'd15}});
    chk("t5_wbeats", 64'(w_cnt), 64'(16));
    chk("t5_err", 64'(err_o), 64'(1));
    chk("t5_fin_lat", 64'(fin_cyc), 64'(b_cyc + 1));
    chk_data("t5", 32'h0, 32'h9000, 16);

    // 6a: start while busy is ignored; err clears on the accepted start
    start_xfer(32'h2000, 32'hA000, 32'd16);
    chk("t6_err_clr", 64'(err_o), 64'(0));
    wait_w(500);
    src_addr_i = 32'h7000; dst_addr_i = 32'h7800; data_qty_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("t6_busy_start_ar", 64'({m_arvalid_o, busy_o}), 64'({1'b0, 1'b1}));
    wait_done(500);
    chk_bursts("t6a", '{{32'h2000, 8'd15}}, '{{32'hA000, 8'd15}});
    chk("t6a_fin_cnt", 64'(fin_cnt), 64'(1));
    chk_data("t6a", 32'h2000, 32'hA000, 16);

    // 6b: reset in the middle of the write burst
    start_xfer(32'h2000, 32'hA000, 32'd16);
    wait_w(500);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", 64'({m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o, m_bready_o}), 64'(0));
    chk("t6_rst_busy", 64'({busy_o, dma_fin_o}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle_valids", 64'({m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o, m_bready_o}), 64'(0));
    chk("t6_idle_status", 64'({busy_o, dma_fin_o, err_o}), 64'(0));

    // 6c: random backpressure on every slave-driven handshake
    bp_en = 1'b1;
    start_xfer(32'h4000, 32'hB000, 32'd17);
    wait_done(3000);
    bp_en = 1'b0;
    chk_bursts("t6c", '{{32'h4000, 8'd15}, {32'h4040, 8'd0}}, '{{32'hB000, 8'd15}, {32'hB040, 8'd0}});
    chk("t6c_wlast", 64'(w_bad), 64'(0));
    chk("t6c_err", 64'(err_o), 64'(0));
    chk("t6c_fin_cnt", 64'(fin_cnt), 64'(1));
    chk_data("t6c", 32'h4000, 32'hB000, 17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
